// File: rtl/mouse_pos_tracker.sv
// Absolute pointer tracker: accumulates PS/2 mouse deltas into saturating X/Y positions,
// with button edge detection, middle-button freeze and a one-hot coarse-X LED bar.
module mouse_pos_tracker #(
  parameter int unsigned XW    = 10,
  parameter int unsigned YW    = 10,
  parameter int unsigned SHIFT = 0,
  parameter int unsigned Y_INV = 1,
  parameter int unsigned LED_N = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m_done_tick,
  input  logic [8:0]       xm,
  input  logic [8:0]       ym,
  input  logic [2:0]       btnm,
  input  logic             en,
  output logic [XW-1:0]    x_pos,
  output logic [YW-1:0]    y_pos,
  output logic [LED_N-1:0] led,
  output logic [2:0]       btn_press,
  output logic             move_tick,
  output logic             frozen
);

  localparam int unsigned LW  = $clog2(LED_N);
  // Sum widths leave room for the sign and for +256 after Y negation.
  localparam int unsigned XSW = ((XW > 10) ? XW : 10) + 2;
  localparam int unsigned YSW = ((YW > 10) ? YW : 10) + 2;

  if (SHIFT > 4) begin : g_bad_shift
    $error("mouse_pos_tracker: SHIFT must be 0..4");
  end
  if (LED_N < 2 || (LED_N & (LED_N - 1)) != 0 || LED_N > (1 << XW)) begin : g_bad_led_n
    $error("mouse_pos_tracker: LED_N must be a power of two in 2..2^XW");
  end

  logic            accept;
  logic [2:0]      btn_prev;
  logic signed [9:0] dx, dy_raw, dy;
  logic [XSW-1:0]  x_sum;
  logic [YSW-1:0]  y_sum;
  logic [XW-1:0]   x_move, x_next;
  logic [YW-1:0]   y_move, y_next;
  logic [LW-1:0]   led_idx;

  assign accept = m_done_tick & en;

  assign dx     = $signed({xm[8], xm}) >>> SHIFT;
  assign dy_raw = $signed({ym[8], ym}) >>> SHIFT;
  assign dy     = (Y_INV != 0) ? -dy_raw : dy_raw;

  // Unsigned adders; the top bit of each sum acts as the sign.
  assign x_sum = {{(XSW - XW){1'b0}}, x_pos} + {{(XSW - 10){dx[9]}}, dx};
  assign y_sum = {{(YSW - YW){1'b0}}, y_pos} + {{(YSW - 10){dy[9]}}, dy};

  always_comb begin
    x_move = x_sum[XSW-1] ? '0 : (|x_sum[XSW-2:XW]) ? '1 : x_sum[XW-1:0];
    y_move = y_sum[YSW-1] ? '0 : (|y_sum[YSW-2:YW]) ? '1 : y_sum[YW-1:0];
  end

  always_comb begin
    x_next = x_move;
    y_next = y_move;
    if (btnm[0]) begin
      x_next = '0;
      y_next = '0;
    end else if (btnm[1]) begin
      x_next = '1;
      y_next = '1;
    end else if (frozen) begin
      x_next = x_pos;
      y_next = y_pos;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_pos     <= '0;
      y_pos     <= '0;
      btn_prev  <= '0;
      btn_press <= '0;
      move_tick <= 1'b0;
      frozen    <= 1'b0;
    end else begin
      move_tick <= 1'b0;
      btn_press <= '0;
      if (accept) begin
        move_tick <= 1'b1;
        btn_press <= btnm & ~btn_prev;
        btn_prev  <= btnm;
        // New freeze state applies from the next packet; this one used the old value.
        if (btnm[2] & ~btn_prev[2]) frozen <= ~frozen;
        x_pos <= x_next;
        y_pos <= y_next;
      end
    end
  end

  assign led_idx = x_pos[XW-1 -: LW];

  // idx 0 lights the MSB, so the lit bit is LED_N-1-idx == ~idx.
  always_comb begin
    led = '0;
    led[~led_idx] = 1'b1;
  end

endmodule

// File: tb/tb_mouse_pos_tracker.sv
// Directed bench for mouse_pos_tracker: default instance plus a SHIFT=2 instance.
module tb_mouse_pos_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic       m_done_tick;
  logic [8:0] xm, ym;
  logic [2:0] btnm;
  logic       en1, en2;

  logic [9:0] x1, y1, x2, y2;
  logic [7:0] led1, led2;
  logic [2:0] bp1, bp2;
  logic       mt1, mt2, fr1, fr2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mouse_pos_tracker dut1 (
    .clk(clk), .reset(reset), .m_done_tick(m_done_tick), .xm(xm), .ym(ym), .btnm(btnm),
    .en(en1), .x_pos(x1), .y_pos(y1), .led(led1), .btn_press(bp1), .move_tick(mt1),
    .frozen(fr1)
  );

  mouse_pos_tracker #(.SHIFT(2)) dut2 (
    .clk(clk), .reset(reset), .m_done_tick(m_done_tick), .xm(xm), .ym(ym), .btnm(btnm),
    .en(en2), .x_pos(x2), .y_pos(y2), .led(led2), .btn_press(bp2), .move_tick(mt2),
    .frozen(fr2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns on the negedge after the sampling edge, when outputs are visible.
  task automatic send(input logic [8:0] x, input logic [8:0] y, input logic [2:0] b);
    @(negedge clk);
    xm = x; ym = y; btnm = b; m_done_tick = 1'b1;
    @(negedge clk);
    m_done_tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; m_done_tick = 1'b0; xm = '0; ym = '0; btnm = '0; en1 = 1'b1; en2 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_x", 32'(x1), 0);
    check("rst_y", 32'(y1), 0);
    check("rst_led", 32'(led1), 32'h80);
    check("rst_frozen", 32'(fr1), 0);
    check("rst_btn_press", 32'(bp1), 0);
    check("rst_move_tick", 32'(mt1), 0);

    // Three +100 moves.
    send(9'h064, 9'h000, 3'b000);
    check("mv1_x", 32'(x1), 100);
    check("mv1_tick", 32'(mt1), 1);
    @(negedge clk);
    check("mv1_tick_low", 32'(mt1), 0);
    send(9'h064, 9'h000, 3'b000);
    check("mv2_x", 32'(x1), 200);
    check("mv2_tick", 32'(mt1), 1);
    send(9'h064, 9'h000, 3'b000);
    check("mv3_x", 32'(x1), 300);
    check("mv3_led", 32'(led1), 32'h20);
    check("mv3_y", 32'(y1), 0);

    // -256 twice: 44 then saturate at 0.
    send(9'h100, 9'h000, 3'b000);
    check("neg1_x", 32'(x1), 44);
    send(9'h100, 9'h000, 3'b000);
    check("neg2_x_sat0", 32'(x1), 0);

    // Reach 1000, then +100 saturates at 1023.
    send(9'h0FF, 9'h000, 3'b000);
    send(9'h0FF, 9'h000, 3'b000);
    send(9'h0FF, 9'h000, 3'b000);
    send(9'h0EB, 9'h000, 3'b000);
    check("x_1000", 32'(x1), 1000);
    send(9'h064, 9'h000, 3'b000);
    check("x_sat_max", 32'(x1), 1023);
    check("led_max", 32'(led1), 32'h01);

    // Y inverted: ym=-10 -> 10, +20 -> 0, -256 -> 256.
    send(9'h000, 9'h1F6, 3'b000);
    check("y_10", 32'(y1), 10);
    send(9'h000, 9'h014, 3'b000);
    check("y_sat0", 32'(y1), 0);
    send(9'h000, 9'h100, 3'b000);
    check("y_256", 32'(y1), 256);

    // SHIFT=2 instance only; dut1 ignores these packets.
    en1 = 1'b0; en2 = 1'b1;
    send(9'h064, 9'h000, 3'b000);
    check("sh_x25", 32'(x2), 25);
    check("en0_tick", 32'(mt1), 0);
    check("en0_x", 32'(x1), 1023);
    send(9'h1FB, 9'h000, 3'b000);
    check("sh_x23", 32'(x2), 23);
    en1 = 1'b1; en2 = 1'b0;

    // Left+right with motion: left wins, both presses reported.
    send(9'h032, 9'h000, 3'b011);
    check("lr_x", 32'(x1), 0);
    check("lr_y", 32'(y1), 0);
    check("lr_press", 32'(bp1), 3'b011);
    @(negedge clk);
    check("lr_press_low", 32'(bp1), 0);
    send(9'h032, 9'h000, 3'b011);
    check("lr_repeat_press", 32'(bp1), 0);

    // Packet with en=0: no change, btn_prev untouched.
    en1 = 1'b0;
    send(9'h032, 9'h000, 3'b100);
    check("en0b_x", 32'(x1), 0);
    check("en0b_frozen", 32'(fr1), 0);
    check("en0b_press", 32'(bp1), 0);
    check("en0b_tick", 32'(mt1), 0);
    en1 = 1'b1;

    // Freeze walk; the toggling packet uses the old frozen value.
    send(9'h00A, 9'h000, 3'b100);
    check("frz_on", 32'(fr1), 1);
    check("frz_on_press", 32'(bp1), 3'b100);
    check("frz_on_x", 32'(x1), 10);
    send(9'h032, 9'h000, 3'b000);
    check("frz_hold_x", 32'(x1), 10);
    send(9'h032, 9'h000, 3'b100);
    check("frz_off", 32'(fr1), 0);
    check("frz_off_x", 32'(x1), 10);
    send(9'h032, 9'h000, 3'b000);
    check("unfrz_x", 32'(x1), 60);
    send(9'h000, 9'h000, 3'b100);
    check("frz2_on", 32'(fr1), 1);
    send(9'h000, 9'h000, 3'b010);
    check("frz_right_x", 32'(x1), 1023);
    check("frz_right_y", 32'(y1), 1023);
    check("frz_right_press", 32'(bp1), 3'b010);
    check("frz_still", 32'(fr1), 1);
    send(9'h000, 9'h000, 3'b001);
    check("frz_left_x", 32'(x1), 0);

    // Reset during a packet wins.
    send(9'h032, 9'h000, 3'b000);
    check("pre_rst_x", 32'(x1), 0);
    @(negedge clk);
    xm = 9'h032; btnm = 3'b000; m_done_tick = 1'b1;
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_frozen", 32'(fr1), 0);
    check("midrst_x", 32'(x1), 0);
    check("midrst_tick", 32'(mt1), 0);
    check("midrst_led", 32'(led1), 32'h80);
    check("midrst_x2", 32'(x2), 0);
    m_done_tick = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
